// File: rtl/spi_adc_scanner.sv
`default_nettype none
// ==========================================================================
// spi_adc_scanner : periodic N-channel SPI ADC scan sequencer and sampler
// Rev 1.0
// ==========================================================================
module spi_adc_scanner #(
  parameter int          NUM_CH        = 4,
  parameter int          CH_W          = 4,
  parameter int          SAMPLE_PERIOD = 2400,
  parameter logic [15:0] CMD_BASE      = 16'h0000,
  parameter int          CH_SHIFT      = 11,
  parameter int          TIMEOUT       = 4096
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_enable,
  input  logic            i_clear_err,
  output logic            o_start_transfer,
  output logic [15:0]     o_data_to_tx,
  input  logic [15:0]     i_data_rx,
  input  logic            i_transfer_done,
  input  logic            i_transfer_busy,
  output logic [15:0]     o_sample_data,
  output logic [CH_W-1:0] o_sample_ch,
  output logic            o_sample_valid,
  output logic            o_frame_done,
  output logic            o_timeout_err,
  output logic            o_overrun_err,
  output logic            o_scan_busy
);

  localparam int                PER_W      = $clog2(SAMPLE_PERIOD + 1);
  localparam int                TMO_W      = $clog2(TIMEOUT + 1);
  localparam logic [PER_W-1:0]  c_PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [TMO_W-1:0]  c_TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [CH_W-1:0]   c_LAST_CH  = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_REQ       = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_STORE     = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CH_W-1:0]  r_ch, w_ch_nxt;
  logic [PER_W-1:0] r_per;
  logic [TMO_W-1:0] r_tmo;
  logic [15:0]      r_tx, r_sample;
  logic             r_done_s1, r_done_s2, r_done_d;
  logic             r_busy_s1, r_busy_s2;
  logic             r_tmo_err, r_ovr_err;
  logic             w_tick, w_done_rise, w_tmo_hit, w_enter_req, w_ovr_evt;
  logic             w_start, w_valid, w_frame, w_capture, w_abort;

  assign w_tick      = i_enable && (r_per == c_PER_LAST);
  assign w_done_rise = r_done_s2 && !r_done_d;
  assign w_tmo_hit   = (r_tmo == c_TMO_LAST);
  assign w_ovr_evt   = w_tick && (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_start     = 1'b0;
    w_valid     = 1'b0;
    w_frame     = 1'b0;
    w_capture   = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          w_state_nxt = S_REQ;
          w_ch_nxt    = '0;
        end
      end
      S_REQ: begin
        // start is held until the master's slow clock has visibly accepted it
        if (w_tmo_hit) begin
          w_abort = 1'b1;
        end else if (r_busy_s2) begin
          w_state_nxt = S_WAIT_DONE;
        end else begin
          w_start = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (w_done_rise) begin
          w_capture   = 1'b1;
          w_state_nxt = S_STORE;
        end else if (w_tmo_hit) begin
          w_abort = 1'b1;
        end
      end
      S_STORE: begin
        w_valid = 1'b1;
        if (!i_enable) begin
          w_state_nxt = S_IDLE;
          w_ch_nxt    = '0;
        end else if (r_ch == c_LAST_CH) begin
          w_frame     = 1'b1;
          w_state_nxt = S_IDLE;
          w_ch_nxt    = '0;
        end else begin
          w_state_nxt = S_REQ;
          w_ch_nxt    = r_ch + CH_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_abort) begin
      w_state_nxt = S_IDLE;
      w_ch_nxt    = '0;
    end
  end

  assign w_enter_req = (w_state_nxt == S_REQ) && (r_state != S_REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ch      <= '0;
      r_per     <= '0;
      r_tmo     <= '0;
      r_tx      <= CMD_BASE;
      r_sample  <= '0;
      r_done_s1 <= 1'b0;
      r_done_s2 <= 1'b0;
      r_done_d  <= 1'b0;
      r_busy_s1 <= 1'b0;
      r_busy_s2 <= 1'b0;
      r_tmo_err <= 1'b0;
      r_ovr_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ch      <= w_ch_nxt;
      r_done_s1 <= i_transfer_done;
      r_done_s2 <= r_done_s1;
      r_done_d  <= r_done_s2;
      r_busy_s1 <= i_transfer_busy;
      r_busy_s2 <= r_busy_s1;

      if (!i_enable || (r_per == c_PER_LAST)) r_per <= '0;
      else                                    r_per <= r_per + PER_W'(1);

      if (w_enter_req)                                           r_tmo <= '0;
      else if ((r_state == S_REQ) || (r_state == S_WAIT_DONE))   r_tmo <= r_tmo + TMO_W'(1);

      if (w_enter_req) r_tx <= CMD_BASE | (16'(w_ch_nxt) << CH_SHIFT);
      if (w_capture)   r_sample <= i_data_rx;

      // an error event in the same cycle as clear_err leaves the flag set
      if (w_abort)          r_tmo_err <= 1'b1;
      else if (i_clear_err) r_tmo_err <= 1'b0;
      if (w_ovr_evt)        r_ovr_err <= 1'b1;
      else if (i_clear_err) r_ovr_err <= 1'b0;
    end
  end

  assign o_start_transfer = w_start;
  assign o_data_to_tx     = r_tx;
  assign o_sample_data    = r_sample;
  assign o_sample_ch      = r_ch;
  assign o_sample_valid   = w_valid;
  assign o_frame_done     = w_frame;
  assign o_timeout_err    = r_tmo_err;
  assign o_overrun_err    = r_ovr_err;
  assign o_scan_busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_adc_scanner.sv
`default_nettype none
// ==========================================================================
// tb_spi_adc_scanner : directed scoreboard bench with a behavioural SPI master
// Rev 1.0
// ==========================================================================
module tb_spi_adc_scanner;

  localparam int PERIOD = 220;

  logic        clk, rst_n, enable, clear_err;
  logic        start_transfer, transfer_done, transfer_busy;
  logic [15:0] data_to_tx, data_rx, sample_data;
  logic [3:0]  sample_ch;
  logic        sample_valid, frame_done, timeout_err, overrun_err, scan_busy;

  spi_adc_scanner #(
    .NUM_CH(4), .CH_W(4), .SAMPLE_PERIOD(PERIOD), .CMD_BASE(16'h0000),
    .CH_SHIFT(11), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_clear_err(clear_err),
    .o_start_transfer(start_transfer), .o_data_to_tx(data_to_tx),
    .i_data_rx(data_rx), .i_transfer_done(transfer_done),
    .i_transfer_busy(transfer_busy), .o_sample_data(sample_data),
    .o_sample_ch(sample_ch), .o_sample_valid(sample_valid),
    .o_frame_done(frame_done), .o_timeout_err(timeout_err),
    .o_overrun_err(overrun_err), .o_scan_busy(scan_busy)
  );

  int errors = 0, checks = 0;
  int cyc = 0, tb_per = 0;
  int busy_delay = 3, xfer_len = 8, hang_ch = -1, exp_next_ch = 0;
  int starts = 0, model_ch = -1, notice_cyc = 0, valid_cnt = 0, frame_cnt = 0;
  int m_ch, m_k;
  bit chk_slow = 0;
  logic        tb_tick;
  logic [19:0] sb[$];
  logic [19:0] m_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // reference sample-period counter: tick when it wraps
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       tb_per <= 0;
    else if (!enable) tb_per <= 0;
    else              tb_per <= (tb_per == PERIOD - 1) ? 0 : tb_per + 1;
  end
  assign tb_tick = enable && (tb_per == PERIOD - 1);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frame(input string tag, input int max);
    int n;
    n = 0;
    while (!frame_done && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(frame_done), 32'd1);
  endtask

  // behavioural SPI master: answers each request with 16'hA000 + channel
  always begin
    @(negedge clk);
    if (rst_n && start_transfer && !transfer_busy) begin
      m_ch        = exp_next_ch;
      exp_next_ch = (exp_next_ch + 1) % 4;
      model_ch    = m_ch;
      notice_cyc  = cyc;
      starts++;
      chk("cmd_word", 32'(data_to_tx), 32'(16'(m_ch) << 11));
      for (int i = 0; i < busy_delay; i++) begin
        if (chk_slow) chk("start_held", 32'(start_transfer), 32'd1);
        @(negedge clk);
      end
      transfer_busy = 1'b1;
      m_k = 0;
      for (int i = 0; i < xfer_len; i++) begin
        @(negedge clk);
        if (start_transfer) m_k++;
      end
      if (chk_slow) chk("start_drop_3cyc", 32'(m_k <= 3 && !start_transfer), 32'd1);
      if (m_ch == hang_ch) begin
        transfer_busy = 1'b0;
      end else begin
        data_rx       = 16'hA000 + 16'(m_ch);
        transfer_done = 1'b1;
        transfer_busy = 1'b0;
        if (rst_n) sb.push_back({4'(m_ch), 16'hA000 + 16'(m_ch)});
        repeat (3) @(negedge clk);
        transfer_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (sample_valid) begin
      valid_cnt++;
      chk("sample_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        m_exp = sb.pop_front();
        chk("sample_ch", 32'(sample_ch), 32'(m_exp[19:16]));
        chk("sample_data", 32'(sample_data), 32'(m_exp[15:0]));
        chk("frame_done_with_last", 32'(frame_done), 32'(m_exp[19:16] == 4'd3));
      end
    end else if (frame_done) begin
      chk("frame_done_alone", 32'(sample_valid), 32'd1);
    end
    if (frame_done) frame_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, f0, v0, n, t0;
    rst_n = 1'b0; enable = 1'b0; clear_err = 1'b0;
    data_rx = '0; transfer_done = 1'b0; transfer_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_start", 32'(start_transfer), 32'd0);
    chk("rst_cmd", 32'(data_to_tx), 32'h0000);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_frame", 32'(frame_done), 32'd0);
    chk("rst_errs", 32'({timeout_err, overrun_err}), 32'd0);
    chk("rst_busy", 32'(scan_busy), 32'd0);
    chk("rst_data", 32'(sample_data), 32'd0);
    chk("rst_ch", 32'(sample_ch), 32'd0);

    // normal frame
    rst_n = 1'b1; enable = 1'b1;
    s0 = starts; f0 = frame_cnt;
    wait_frame("normal_frame", 400);
    @(negedge clk);
    chk("normal_starts", 32'(starts - s0), 32'd4);
    chk("normal_frames", 32'(frame_cnt - f0), 32'd1);
    chk("normal_sb_empty", 32'(sb.size()), 32'd0);
    chk("normal_idle", 32'(scan_busy), 32'd0);
    chk("normal_no_err", 32'({timeout_err, overrun_err}), 32'd0);

    // slow start: busy 40 cycles after start
    busy_delay = 40; xfer_len = 6; chk_slow = 1'b1;
    s0 = starts; f0 = frame_cnt;
    wait_frame("slow_frame", 400);
    @(negedge clk);
    chk_slow = 1'b0;
    chk("slow_starts", 32'(starts - s0), 32'd4);
    chk("slow_frames", 32'(frame_cnt - f0), 32'd1);
    chk("slow_no_err", 32'({timeout_err, overrun_err}), 32'd0);

    // overrun: frame longer than the sample period
    busy_delay = 45; xfer_len = 10;
    s0 = starts; f0 = frame_cnt;
    wait_frame("ovr_frame", 500);
    @(negedge clk);
    chk("ovr_flag", 32'(overrun_err), 32'd1);
    chk("ovr_starts", 32'(starts - s0), 32'd4);
    chk("ovr_frames", 32'(frame_cnt - f0), 32'd1);
    chk("ovr_no_tmo", 32'(timeout_err), 32'd0);
    clear_err = 1'b1; @(negedge clk); clear_err = 1'b0;
    chk("ovr_clear", 32'(overrun_err), 32'd0);
    n = 0;
    while (!(tb_tick && scan_busy) && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("ovr_tick_in_frame", 32'(tb_tick && scan_busy), 32'd1);
    clear_err = 1'b1; @(negedge clk); clear_err = 1'b0;
    chk("ovr_set_wins", 32'(overrun_err), 32'd1);
    wait_frame("ovr_frame2", 200);
    @(negedge clk);
    enable = 1'b0; clear_err = 1'b1; @(negedge clk); clear_err = 1'b0;
    chk("ovr_clear2", 32'(overrun_err), 32'd0);

    // timeout: channel 1 never completes
    busy_delay = 3; xfer_len = 8; hang_ch = 1; exp_next_ch = 0; model_ch = -1;
    s0 = starts; f0 = frame_cnt; enable = 1'b1;
    n = 0;
    while (!(model_ch == 1 && starts - s0 == 2) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_ch1_started", 32'(model_ch), 32'd1);
    t0 = notice_cyc;
    n = 0;
    while (!timeout_err && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_flag", 32'(timeout_err), 32'd1);
    chk("tmo_latency_64", 32'((cyc - t0) >= 63 && (cyc - t0) <= 65), 32'd1);
    @(negedge clk);
    chk("tmo_idle", 32'(scan_busy), 32'd0);
    chk("tmo_no_start", 32'(start_transfer), 32'd0);
    chk("tmo_no_frame", 32'(frame_cnt - f0), 32'd0);
    chk("tmo_sb_empty", 32'(sb.size()), 32'd0);
    hang_ch = -1; exp_next_ch = 0;
    s0 = starts; f0 = frame_cnt;
    wait_frame("tmo_restart_frame", 400);
    @(negedge clk);
    chk("tmo_restart_starts", 32'(starts - s0), 32'd4);
    chk("tmo_restart_frames", 32'(frame_cnt - f0), 32'd1);
    clear_err = 1'b1; @(negedge clk); clear_err = 1'b0;
    chk("tmo_clear", 32'(timeout_err), 32'd0);

    // enable dropped during the ch=2 transfer
    s0 = starts; f0 = frame_cnt; v0 = valid_cnt;
    n = 0;
    while (!(model_ch == 2 && starts - s0 == 3 && transfer_busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drop_ch2_active", 32'(transfer_busy), 32'd1);
    enable = 1'b0;
    repeat (100) @(negedge clk);
    chk("drop_valids", 32'(valid_cnt - v0), 32'd3);
    chk("drop_starts", 32'(starts - s0), 32'd3);
    chk("drop_frames", 32'(frame_cnt - f0), 32'd0);
    chk("drop_idle", 32'(scan_busy), 32'd0);
    chk("drop_sb_empty", 32'(sb.size()), 32'd0);

    // asynchronous reset while waiting for ch=1 done
    exp_next_ch = 0; model_ch = -1; enable = 1'b1;
    s0 = starts;
    n = 0;
    while (!(model_ch == 1 && starts - s0 == 2 && transfer_busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("rst_pre_busy", 32'(scan_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_start", 32'(start_transfer), 32'd0);
    chk("arst_cmd", 32'(data_to_tx), 32'h0000);
    chk("arst_busy", 32'(scan_busy), 32'd0);
    chk("arst_data", 32'(sample_data), 32'd0);
    chk("arst_ch", 32'(sample_ch), 32'd0);
    chk("arst_strobes", 32'({sample_valid, frame_done, timeout_err, overrun_err}), 32'd0);
    repeat (20) @(negedge clk);
    exp_next_ch = 0; sb.delete();
    s0 = starts; f0 = frame_cnt;
    rst_n = 1'b1;
    n = 0;
    while (!start_transfer && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("arst_first_req_at_tick", 32'(n), 32'(PERIOD));
    wait_frame("arst_frame", 300);
    @(negedge clk);
    chk("arst_starts", 32'(starts - s0), 32'd4);
    chk("arst_frames", 32'(frame_cnt - f0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
